// File: rtl/kyogenrv_avm_arbiter_if.sv
// ---------------------------------------------------------------------------
// kyogenrv_avm_arbiter_if
// Bundles the three Avalon-MM ports around the kyogenrv_avm_arbiter:
//   i_*  imem master port   (read only)
//   d_*  dmem master port   (read / write, byte enables)
//   m_*  shared slave port  (toward the memory)
// Modports:
//   slave  - the arbiter's view: it receives the core requests and drives
//            the stalls/read data back, and it drives the shared slave command.
//   master - the environment's view: the cores issue requests and the memory
//            answers the slave command.
// Parameters: AW address width, DW data width (byteenable width DW/8).
// ---------------------------------------------------------------------------
interface kyogenrv_avm_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // imem port
    logic              i_read;
    logic [AW-1:0]     i_addr;
    logic              i_waitrequest;
    logic [DW-1:0]     i_readdata;
    logic              i_readdatavalid;

    // dmem port
    logic              d_read;
    logic              d_write;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_writedata;
    logic [DW/8-1:0]   d_byteenable;
    logic              d_waitrequest;
    logic [DW-1:0]     d_readdata;
    logic              d_readdatavalid;

    // shared slave port
    logic              m_read;
    logic              m_write;
    logic [AW-1:0]     m_address;
    logic [DW-1:0]     m_writedata;
    logic [DW/8-1:0]   m_byteenable;
    logic              m_waitrequest;
    logic [DW-1:0]     m_readdata;
    logic              m_readdatavalid;

    modport slave (
        input  i_read, i_addr,
        output i_waitrequest, i_readdata, i_readdatavalid,
        input  d_read, d_write, d_addr, d_writedata, d_byteenable,
        output d_waitrequest, d_readdata, d_readdatavalid,
        output m_read, m_write, m_address, m_writedata, m_byteenable,
        input  m_waitrequest, m_readdata, m_readdatavalid
    );

    modport master (
        output i_read, i_addr,
        input  i_waitrequest, i_readdata, i_readdatavalid,
        output d_read, d_write, d_addr, d_writedata, d_byteenable,
        input  d_waitrequest, d_readdata, d_readdatavalid,
        input  m_read, m_write, m_address, m_writedata, m_byteenable,
        output m_waitrequest, m_readdata, m_readdatavalid
    );
endinterface

// File: rtl/kyogenrv_avm_arbiter.sv
// ---------------------------------------------------------------------------
// kyogenrv_avm_arbiter
// Two-master (imem, dmem) to one-slave Avalon-MM arbiter. Serialises
// instruction fetches and data loads/stores onto one shared memory slave,
// one transfer in flight at a time, and routes waitrequest / readdata back
// to the granted master.
//
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-high
//   bus    - kyogenrv_avm_arbiter_if.slave (i_*, d_*, m_* signal groups)
//
// FSM: IDLE -> ISSUE -> (RDWAIT) -> IDLE, owner bit own (0 imem, 1 dmem).
// Read data is registered, so read latency seen by a master is the slave
// latency + 1. Read data outputs hold their value between valid pulses.
//
// Build option:
//   KRV_ARB_RR_EN  defined   - round-robin: last-granted master loses a tie
//                              (tie-break resets to "imem last").
//                  undefined - fixed priority: dmem wins every tie.
// ---------------------------------------------------------------------------
module kyogenrv_avm_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    kyogenrv_avm_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic            own, own_nxt;
    logic            i_req, d_req, grant_d;
    logic            own_read, own_write;
    logic            rd_done;

    logic            m_read_c, m_write_c;
    logic [AW-1:0]   m_address_c;
    logic [DW/8-1:0] m_byteenable_c;
    logic            i_wait_c, d_wait_c;

    logic [DW-1:0]   i_rdata_p1, d_rdata_p1;
    logic            i_vld_p1, d_vld_p1;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

`ifdef KRV_ARB_RR_EN
    // last_d: 1 when dmem was the most recent grant; resets to "imem last"
    // so dmem takes the first tie.
    logic last_d;

    assign grant_d = d_req & (~i_req | ~last_d);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_d <= 1'b0;
        end else if (state == ST_IDLE && (i_req || d_req)) begin
            last_d <= grant_d;
        end
    end
`else
    // Fixed priority keeps loads/stores from starving behind fetch.
    assign grant_d = d_req;
`endif

    // Owner's request; read wins when dmem raises read and write together.
    assign own_read  = own ? bus.d_read : bus.i_read;
    assign own_write = own & bus.d_write & ~bus.d_read;
    assign rd_done   = (state == ST_RDWAIT) && bus.m_readdatavalid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            own   <= 1'b0;
        end else begin
            state <= state_nxt;
            own   <= own_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        own_nxt        = own;
        m_read_c       = 1'b0;
        m_write_c      = 1'b0;
        m_address_c    = own ? bus.d_addr : bus.i_addr;
        m_byteenable_c = own ? bus.d_byteenable : '1;
        i_wait_c       = 1'b1;
        d_wait_c       = 1'b1;

        unique case (state)
            ST_IDLE: begin
                if (i_req || d_req) begin
                    own_nxt   = grant_d;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!own_read && !own_write) begin
                    // Owner withdrew its request: abandon without a command.
                    state_nxt = ST_IDLE;
                end else begin
                    m_read_c  = own_read;
                    m_write_c = own_write;
                    if (own) d_wait_c = bus.m_waitrequest;
                    else     i_wait_c = bus.m_waitrequest;
                    if (!bus.m_waitrequest) begin
                        // A write is complete once the slave accepts it.
                        state_nxt = own_read ? ST_RDWAIT : ST_IDLE;
                    end
                end
            end
            ST_RDWAIT: begin
                if (bus.m_readdatavalid) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---- read-return stage (p1): slave data registered to the owner ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            i_vld_p1   <= 1'b0;
            d_vld_p1   <= 1'b0;
            i_rdata_p1 <= '0;
            d_rdata_p1 <= '0;
        end else begin
            i_vld_p1 <= rd_done & ~own;
            d_vld_p1 <= rd_done & own;
            if (rd_done && !own) i_rdata_p1 <= bus.m_readdata;
            if (rd_done &&  own) d_rdata_p1 <= bus.m_readdata;
        end
    end

    assign bus.m_read          = m_read_c;
    assign bus.m_write         = m_write_c;
    assign bus.m_address       = m_address_c;
    assign bus.m_writedata     = bus.d_writedata;
    assign bus.m_byteenable    = m_byteenable_c;

    assign bus.i_waitrequest   = i_wait_c;
    assign bus.i_readdata      = i_rdata_p1;
    assign bus.i_readdatavalid = i_vld_p1;

    assign bus.d_waitrequest   = d_wait_c;
    assign bus.d_readdata      = d_rdata_p1;
    assign bus.d_readdatavalid = d_vld_p1;

endmodule

// File: tb/tb_kyogenrv_avm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_kyogenrv_avm_arbiter
// Directed testbench for kyogenrv_avm_arbiter. Inputs are driven 1 time unit
// after the rising edge and outputs are sampled 3 time units after it.
// Grant-order expectations follow KRV_ARB_RR_EN when it is defined.
// ---------------------------------------------------------------------------
module tb_kyogenrv_avm_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    kyogenrv_avm_arbiter_if #(.AW(32), .DW(32)) bus ();

    kyogenrv_avm_arbiter #(.AW(32), .DW(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_addr;
        bit          found;

        bus.i_read          = 1'b0;
        bus.i_addr          = '0;
        bus.d_read          = 1'b0;
        bus.d_write         = 1'b0;
        bus.d_addr          = '0;
        bus.d_writedata     = '0;
        bus.d_byteenable    = '0;
        bus.m_waitrequest   = 1'b0;
        bus.m_readdata      = '0;
        bus.m_readdatavalid = 1'b0;

        // ---------------- reset state ----------------
        tick();
        settle();
        check("rst_i_wait", bus.i_waitrequest, 1);
        check("rst_d_wait", bus.d_waitrequest, 1);
        check("rst_i_vld", bus.i_readdatavalid, 0);
        check("rst_d_vld", bus.d_readdatavalid, 0);
        check("rst_i_rdata", bus.i_readdata, 0);
        check("rst_d_rdata", bus.d_readdata, 0);
        check("rst_m_read", bus.m_read, 0);
        check("rst_m_write", bus.m_write, 0);
        tick();
        reset = 1'b0;
        tick();

        // ---------------- imem read, latency 1 ----------------
        bus.i_read = 1'b1;
        bus.i_addr = 32'h100;
        settle();
        check("rd_idle_m_read", bus.m_read, 0);
        check("rd_idle_i_wait", bus.i_waitrequest, 1);
        tick();
        settle();
        check("rd_m_read", bus.m_read, 1);
        check("rd_m_addr", bus.m_address, 32'h100);
        check("rd_m_be", bus.m_byteenable, 32'hF);
        check("rd_i_wait", bus.i_waitrequest, 0);
        check("rd_d_wait", bus.d_waitrequest, 1);
        tick();
        bus.i_read          = 1'b0;
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = 32'hDEADBEEF;
        settle();
        check("rd_rdwait_m_read", bus.m_read, 0);
        check("rd_early_vld", bus.i_readdatavalid, 0);
        tick();
        bus.m_readdatavalid = 1'b0;
        settle();
        check("rd_i_vld", bus.i_readdatavalid, 1);
        check("rd_i_rdata", bus.i_readdata, 32'hDEADBEEF);
        check("rd_d_vld", bus.d_readdatavalid, 0);
        tick();
        settle();
        check("rd_vld_pulse", bus.i_readdatavalid, 0);
        check("rd_i_rdata_hold", bus.i_readdata, 32'hDEADBEEF);

        // ---------------- dmem write, 3 wait cycles ----------------
        tick();
        bus.d_write       = 1'b1;
        bus.d_addr        = 32'h2000;
        bus.d_writedata   = 32'h12345678;
        bus.d_byteenable  = 4'h3;
        bus.m_waitrequest = 1'b1;
        settle();
        check("wr_idle_d_wait", bus.d_waitrequest, 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.m_waitrequest = (k < 3);
            settle();
            check("wr_m_write", bus.m_write, 1);
            check("wr_m_read", bus.m_read, 0);
            check("wr_m_addr", bus.m_address, 32'h2000);
            check("wr_m_wdata", bus.m_writedata, 32'h12345678);
            check("wr_m_be", bus.m_byteenable, 32'h3);
            check("wr_d_wait", bus.d_waitrequest, (k == 3) ? 32'd0 : 32'd1);
            tick();
        end
        bus.d_write = 1'b0;
        settle();
        check("wr_done_m_write", bus.m_write, 0);
        check("wr_done_d_wait", bus.d_waitrequest, 1);

        // ---------------- simultaneous reads: dmem first ----------------
        tick();
        bus.i_read = 1'b1;
        bus.i_addr = 32'h100;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h300;
        bus.d_byteenable = 4'h5;
        tick();
        settle();
        check("tie_m_addr", bus.m_address, 32'h300);
        check("tie_m_read", bus.m_read, 1);
        check("tie_d_wait", bus.d_waitrequest, 0);
        check("tie_i_wait", bus.i_waitrequest, 1);
        tick();
        bus.d_read = 1'b0;
        settle();
        check("tie_rdwait_i_wait", bus.i_waitrequest, 1);
        check("tie_rdwait_m_read", bus.m_read, 0);
        tick();
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = 32'hAAAA5555;
        settle();
        check("tie_rdwait2_i_wait", bus.i_waitrequest, 1);
        tick();
        bus.m_readdatavalid = 1'b0;
        settle();
        check("tie_d_vld", bus.d_readdatavalid, 1);
        check("tie_d_rdata", bus.d_readdata, 32'hAAAA5555);
        check("tie_i_vld", bus.i_readdatavalid, 0);
        check("tie_idle_m_read", bus.m_read, 0);
        tick();
        settle();
        check("tie_i_m_read", bus.m_read, 1);
        check("tie_i_m_addr", bus.m_address, 32'h100);
        check("tie_i_m_be", bus.m_byteenable, 32'hF);
        check("tie_i_i_wait", bus.i_waitrequest, 0);
        tick();
        bus.i_read          = 1'b0;
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = 32'h11112222;
        tick();
        bus.m_readdatavalid = 1'b0;
        settle();
        check("tie_i_vld2", bus.i_readdatavalid, 1);
        check("tie_i_rdata2", bus.i_readdata, 32'h11112222);
        check("tie_d_rdata_hold", bus.d_readdata, 32'hAAAA5555);

        // ---------------- repeated ties, both masters always requesting ----------------
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        bus.i_read = 1'b1;
        bus.i_addr = 32'h100;
        bus.d_read = 1'b1;
        bus.d_addr = 32'h300;
        for (int g = 0; g < 4; g++) begin
            found = 1'b0;
            for (int w = 0; w < 8 && !found; w++) begin
                settle();
                if (bus.m_read) found = 1'b1;
                else tick();
            end
            if (!found) check("seq_grant_wait", bus.m_read, 1);
`ifdef KRV_ARB_RR_EN
            exp_addr = (g % 2 == 0) ? 32'h300 : 32'h100;
`else
            exp_addr = 32'h300;
`endif
            check("seq_grant", bus.m_address, exp_addr);
            tick();
            if (g == 3) begin
                bus.i_read = 1'b0;
                bus.d_read = 1'b0;
            end
            bus.m_readdatavalid = 1'b1;
            bus.m_readdata      = 32'hC0DE0000 + g;
            tick();
            bus.m_readdatavalid = 1'b0;
        end

        // ---------------- owner drops request in ISSUE ----------------
        tick();
        bus.d_read = 1'b1;
        bus.d_addr = 32'h400;
        tick();
        bus.d_read = 1'b0;
        settle();
        check("drop_m_read", bus.m_read, 0);
        check("drop_m_write", bus.m_write, 0);
        tick();
        bus.i_read = 1'b1;
        bus.i_addr = 32'h500;
        tick();
        settle();
        check("drop_next_m_read", bus.m_read, 1);
        check("drop_next_m_addr", bus.m_address, 32'h500);
        tick();
        bus.i_read          = 1'b0;
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = 32'h0BADF00D;
        tick();
        bus.m_readdatavalid = 1'b0;
        settle();
        check("drop_next_i_rdata", bus.i_readdata, 32'h0BADF00D);

        // ---------------- reset during RDWAIT ----------------
        tick();
        bus.i_read = 1'b1;
        bus.i_addr = 32'h600;
        tick();
        tick();
        bus.i_read = 1'b0;
        reset      = 1'b1;
        settle();
        check("rstmid_i_wait", bus.i_waitrequest, 1);
        check("rstmid_m_read", bus.m_read, 0);
        check("rstmid_i_rdata", bus.i_readdata, 0);
        tick();
        reset = 1'b0;
        tick();
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = 32'h55;
        tick();
        bus.m_readdatavalid = 1'b0;
        settle();
        check("rstmid_i_vld", bus.i_readdatavalid, 0);
        check("rstmid_d_vld", bus.d_readdatavalid, 0);
        check("rstmid_i_rdata2", bus.i_readdata, 0);
        check("rstmid_d_rdata2", bus.d_readdata, 0);
        tick();
        settle();
        check("rstmid_i_vld2", bus.i_readdatavalid, 0);
        check("rstmid_idle_m_read", bus.m_read, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
